// File: rtl/norm_shift_unit.sv
// Iterative 16-bit normalizer. Finds the left-shift count that moves the
// leading one to bit 15, resolving one barrel stage (8, 4, 2, 1) per clock.
module norm_shift_unit (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [15:0] i_value,
  output logic        o_busy,
  output logic        o_done,
  output logic [3:0]  o_count,
  output logic [15:0] o_result,
  output logic        o_zero
);

  typedef enum logic [2:0] {
    StIdle,
    StS8,
    StS4,
    StS2,
    StS1,
    StDone
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] w_q, w_d;
  logic [3:0]  c_q, c_d;
  logic        zero_q, zero_d;

  // Next-state and datapath: accept in IDLE/DONE, otherwise resolve one stage.
  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    c_d     = c_q;
    zero_d  = zero_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (i_start) begin
          w_d     = i_value;
          c_d     = 4'd0;
          zero_d  = (i_value == 16'h0000);
          state_d = StS8;
        end else begin
          state_d = StIdle;
        end
      end
      StS8: begin
        if (w_q[15:8] == 8'h00) begin
          w_d    = {w_q[7:0], 8'h00};
          c_d[3] = 1'b1;
        end
        state_d = StS4;
      end
      StS4: begin
        if (w_q[15:12] == 4'h0) begin
          w_d    = {w_q[11:0], 4'h0};
          c_d[2] = 1'b1;
        end
        state_d = StS2;
      end
      StS2: begin
        if (w_q[15:14] == 2'b00) begin
          w_d    = {w_q[13:0], 2'b00};
          c_d[1] = 1'b1;
        end
        state_d = StS1;
      end
      StS1: begin
        if (!w_q[15]) begin
          w_d    = {w_q[14:0], 1'b0};
          c_d[0] = 1'b1;
        end
        state_d = StDone;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and working registers; reset aborts any operation at once.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= StIdle;
      w_q     <= 16'h0000;
      c_q     <= 4'd0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      c_q     <= c_d;
      zero_q  <= zero_d;
    end
  end

  // Outputs decode registered state only, so no input reaches them combinationally.
  always_comb begin
    o_busy   = (state_q == StS8) || (state_q == StS4) ||
               (state_q == StS2) || (state_q == StS1);
    o_done   = (state_q == StDone);
    o_count  = c_q;
    o_result = w_q;
    o_zero   = zero_q;
  end

endmodule

// File: tb/tb_norm_shift_unit.sv
// Directed and swept checks for norm_shift_unit.
module tb_norm_shift_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] value;
  logic        busy;
  logic        done;
  logic [3:0]  count;
  logic [15:0] result;
  logic        zero;

  int errors = 0;
  int checks = 0;

  norm_shift_unit dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_start  (start),
    .i_value  (value),
    .o_busy   (busy),
    .o_done   (done),
    .o_count  (count),
    .o_result (result),
    .o_zero   (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int ref_clz(input logic [15:0] v);
    int n = 0;
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) return n;
      n++;
    end
    return 15;
  endfunction

  // Pulse start for one edge, then wait (bounded) for o_done; lat counts from the accepting edge.
  task automatic do_op(input logic [15:0] v, output int lat);
    @(negedge clk);
    start = 1'b1;
    value = v;
    @(negedge clk);
    start = 1'b0;
    value = 16'($urandom);
    lat = 1;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    value = 16'h0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", done); end
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count got=%0d want=0", count); end
    checks++; if (result !== 16'h0) begin errors++; $display("FAIL reset_result got=%h want=0000", result); end
    checks++; if (zero !== 1'b0) begin errors++; $display("FAIL reset_zero got=%b want=0", zero); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    @(negedge clk);
    start = 1'b1;
    value = 16'h1234;
    @(negedge clk);
    start = 1'b0;
    value = 16'hFFFF;
    // After edges 1..4 busy, after edge 5 done.
    for (int e = 1; e <= 5; e++) begin
      logic want_busy;
      want_busy = (e <= 4);
      checks++;
      if (busy !== want_busy || done !== !want_busy) begin
        errors++;
        $display("FAIL basic_edge%0d busy=%b done=%b want busy=%b done=%b", e, busy, done,
                 want_busy, !want_busy);
      end
      if (e < 5) @(negedge clk);
    end
    checks++; if (count !== 4'd3) begin errors++; $display("FAIL basic_count got=%0d want=3", count); end
    checks++; if (result !== 16'h91A0) begin errors++; $display("FAIL basic_result got=%h want=91a0", result); end
    checks++; if (zero !== 1'b0) begin errors++; $display("FAIL basic_zero got=%b want=0", zero); end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || result !== 16'h91A0 || count !== 4'd3) begin
      errors++;
      $display("FAIL basic_hold done=%b busy=%b count=%0d result=%h want 0 0 3 91a0",
               done, busy, count, result);
    end
  endtask

  task automatic test_boundaries();
    logic [15:0] vin  [3] = '{16'h8000, 16'h0001, 16'h0000};
    logic [3:0]  vcnt [3] = '{4'd0, 4'd15, 4'd15};
    logic [15:0] vres [3] = '{16'h8000, 16'h8000, 16'h0000};
    logic        vz   [3] = '{1'b0, 1'b0, 1'b1};
    int lat;
    for (int i = 0; i < 3; i++) begin
      do_op(vin[i], lat);
      checks++;
      if (lat != 5 || count !== vcnt[i] || result !== vres[i] || zero !== vz[i]) begin
        errors++;
        $display("FAIL boundary_%h lat=%0d count=%0d result=%h zero=%b want 5 %0d %h %b",
                 vin[i], lat, count, result, zero, vcnt[i], vres[i], vz[i]);
      end
    end
  endtask

  task automatic test_ignore_busy();
    int dones = 0;
    @(negedge clk);
    start = 1'b1;
    value = 16'h00F0;
    @(negedge clk);            // state S8
    start = 1'b0;
    @(negedge clk);            // state S4: re-pulse start
    start = 1'b1;
    value = 16'hFFFF;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (done) begin
        dones++;
        checks++;
        if (count !== 4'd8 || result !== 16'hF000) begin
          errors++;
          $display("FAIL ignore_result count=%0d result=%h want 8 f000", count, result);
        end
      end
      @(negedge clk);
    end
    checks++;
    if (dones != 1) begin errors++; $display("FAIL ignore_done_pulses got=%0d want=1", dones); end
  endtask

  task automatic test_back_to_back();
    int lat;
    int gap = 0;
    do_op(16'h0F00, lat);
    checks++;
    if (!done || count !== 4'd4 || result !== 16'hF000) begin
      errors++;
      $display("FAIL b2b_first done=%b count=%0d result=%h want 1 4 f000", done, count, result);
    end
    start = 1'b1;              // still in the DONE cycle
    value = 16'h0003;
    @(negedge clk);
    start = 1'b0;
    gap = 1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_accept done=%b busy=%b want 0 1", done, busy);
    end
    while (!done && gap < 20) begin
      @(negedge clk);
      gap++;
    end
    checks++;
    if (gap != 5) begin errors++; $display("FAIL b2b_gap got=%0d want=5", gap); end
    checks++;
    if (count !== 4'd14 || result !== 16'hC000) begin
      errors++;
      $display("FAIL b2b_second count=%0d result=%h want 14 c000", count, result);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    int dones = 0;
    @(negedge clk);
    start = 1'b1;
    value = 16'h0400;
    @(negedge clk);            // S8
    start = 1'b0;
    @(negedge clk);            // S4
    @(negedge clk);            // S2
    #1 rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || count !== 4'd0 || result !== 16'h0 || zero !== 1'b0) begin
      errors++;
      $display("FAIL midreset_outputs busy=%b done=%b count=%0d result=%h zero=%b want all 0",
               busy, done, count, result, zero);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (done) dones++;
      @(negedge clk);
    end
    checks++;
    if (dones != 0) begin errors++; $display("FAIL midreset_no_done got=%0d want=0", dones); end
    do_op(16'h0400, lat);
    checks++;
    if (lat != 5 || count !== 4'd5 || result !== 16'h8000 || zero !== 1'b0) begin
      errors++;
      $display("FAIL midreset_fresh lat=%0d count=%0d result=%h zero=%b want 5 5 8000 0",
               lat, count, result, zero);
    end
  endtask

  task automatic test_sweep();
    int lat;
    logic [15:0] v;
    for (int i = 0; i < 2000; i++) begin
      v = 16'($urandom) >> $urandom_range(0, 15);
      do_op(v, lat);
      checks++;
      if (lat != 5 || int'(count) != ref_clz(v) || (result >> count) !== v ||
          zero !== (v == 16'h0) || (v != 16'h0 && result[15] !== 1'b1)) begin
        errors++;
        $display("FAIL sweep_%h lat=%0d count=%0d result=%h zero=%b want count=%0d",
                 v, lat, count, result, zero, ref_clz(v));
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundaries();
    test_ignore_busy();
    test_back_to_back();
    test_reset_mid();
    test_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
